// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - MEM-stage multi-cycle data memory access controller
//
// Runs a load or store over a req/ack memory port. While the access is
// outstanding it asks the hazard unit to freeze the pipeline, then lets the
// pipeline advance for exactly one cycle. It also captures load data, flags
// timeouts and counts stall cycles.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-high reset
//   MemReadM   - load in MEM stage
//   MemWriteM  - store in MEM stage (wins when both are high)
//   addrM      - access address
//   wdataM     - store data
//   mem_ack    - memory completion strobe (one cycle)
//   mem_rdata  - load data, valid with mem_ack
//   stop       - pipeline freeze request
//   rdataM     - captured load data toward MEM/WB
//   mem_req    - access request, held until ack or abort
//   mem_we     - 1 = write, 0 = read, valid with mem_req
//   mem_addr   - memory address
//   mem_wdata  - memory write data
//   mem_err    - sticky timeout flag
//   stall_cnt  - saturating count of cycles with stop high
module mem_wait_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [ADDR_WIDTH-1:0] addrM,
   input  logic [DATA_WIDTH-1:0] wdataM,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stop,
   output logic [DATA_WIDTH-1:0] rdataM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_err,
   output logic [15:0]           stall_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter value seen during the last allowed BUSY cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] to_cnt;
   logic       access;

   assign access    = MemReadM | MemWriteM;
   assign mem_addr  = addrM;
   assign mem_wdata = wdataM;

   // The request is raised in the same cycle the access appears in IDLE so a
   // zero-wait memory costs only one stall cycle. DONE deliberately drops the
   // request even though the completed access is still on MemReadM/MemWriteM.
   always_comb begin
      stop    = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (access) begin
                  stop    = 1'b1;
                  mem_req = 1'b1;
                  mem_we  = MemWriteM;
               end
            end
            BUSY: begin
               stop    = 1'b1;
               mem_req = 1'b1;
               mem_we  = MemWriteM;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         to_cnt    <= 8'd0;
         rdataM    <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= 16'd0;
      end else begin
         if (stop && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;

         case (state)
            IDLE: begin
               to_cnt <= 8'd0;
               if (access) begin
                  if (mem_ack) begin
                     state <= DONE;
                     if (!MemWriteM)
                        rdataM <= mem_rdata;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  state  <= DONE;
                  to_cnt <= 8'd0;
                  if (!MemWriteM)
                     rdataM <= mem_rdata;
               end else if (to_cnt == TO_LAST) begin
                  // Abort: a timed-out load returns zero rather than stale data.
                  state   <= DONE;
                  to_cnt  <= 8'd0;
                  mem_err <= 1'b1;
                  if (!MemWriteM)
                     rdataM <= '0;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            default: begin
               state  <= IDLE;
               to_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule
